// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and counter sizing for the scan chain controller.
package scan_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE_ST} state_e;

   function automatic int cnt_w(input int len);
      return (len > 2) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// scan_chain_ctrl_if: request, pattern and chain-side signals of the scan controller.
interface scan_chain_ctrl_if #(parameter int CHAIN_LEN = 16, parameter int FAIL_CNT_W = 8);

   logic                  start, ready, se, si, so, done, fail;
   logic [CHAIN_LEN-1:0]  pat_in, exp_in, mask_in, rsp;
   logic [FAIL_CNT_W-1:0] fail_cnt;

   modport master (
      output start, pat_in, exp_in, mask_in, so,
      input  ready, se, si, done, rsp, fail, fail_cnt
   );

   modport slave (
      input  start, pat_in, exp_in, mask_in, so,
      output ready, se, si, done, rsp, fail, fail_cnt
   );

endinterface

// File: rtl/scan_shift_reg.sv
// scan_shift_reg: parallel-load register that shifts toward the MSB, taking ser_i into bit 0.
module scan_shift_reg #(parameter int W = 16) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] par_i,
   input  logic         ser_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q, sr_d;

   always_comb sr_d = load_i ? par_i : shift_i ? {sr_q[W-2:0], ser_i} : sr_q;

   always_ff @(posedge clk_i)
      if (!rstn_i) sr_q <= '0;
      else         sr_q <= sr_d;

   assign q_o = sr_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a pattern into a negedge scan chain, pulses capture,
// unloads and compares the response, and counts failing patterns.
module scan_chain_ctrl import scan_pkg::*; #(
   parameter int   CHAIN_LEN  = 16,
   parameter int   FAIL_CNT_W = 8,
   parameter logic FILL_VAL   = 1'b0
) (
   input logic              CLK,
   input logic              RSTN,
   scan_chain_ctrl_if.slave bus
);

   localparam int CNT_W = cnt_w(CHAIN_LEN);

   state_e                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  se_q, ready_q, done_q, fail_q;
   logic [FAIL_CNT_W-1:0] fail_cnt_q;
   logic [CHAIN_LEN-1:0]  exp_q, mask_q, pat_q, rsp_q;
   logic                  accept, last, sample, mis;

   assign accept = bus.start & ready_q;
   assign last   = cnt_q == CNT_W'(CHAIN_LEN - 1);
   assign sample = (state_q == CAPTURE) | ((state_q == UNLOAD) & ~last);
   assign mis    = |((rsp_q ^ exp_q) & mask_q);

   // The pattern register's MSB is SI: after CHAIN_LEN shifts it holds only FILL_VAL.
   scan_shift_reg #(.W(CHAIN_LEN)) u_pat (
      .clk_i   (CLK),
      .rstn_i  (RSTN),
      .load_i  (accept),
      .shift_i (state_q == LOAD),
      .par_i   (bus.pat_in),
      .ser_i   (FILL_VAL),
      .q_o     (pat_q)
   );

   // SO arrives from position CHAIN_LEN-1 downward, so shifting up lands RSP[i] in place.
   scan_shift_reg #(.W(CHAIN_LEN)) u_rsp (
      .clk_i   (CLK),
      .rstn_i  (RSTN),
      .load_i  (1'b0),
      .shift_i (sample),
      .par_i   ('0),
      .ser_i   (bus.so),
      .q_o     (rsp_q)
   );

   always_ff @(posedge CLK)
      if (!RSTN) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         se_q       <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
         fail_cnt_q <= '0;
         exp_q      <= '0;
         mask_q     <= '0;
      end else
         case (state_q)
            IDLE: if (accept) begin
               exp_q   <= bus.exp_in;
               mask_q  <= bus.mask_in;
               cnt_q   <= '0;
               se_q    <= 1'b1;
               ready_q <= 1'b0;
               state_q <= LOAD;
            end
            LOAD: begin
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  cnt_q   <= '0;
                  se_q    <= 1'b0;
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               se_q    <= 1'b1;
               state_q <= UNLOAD;
            end
            UNLOAD: begin
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  cnt_q   <= '0;
                  se_q    <= 1'b0;
                  done_q  <= 1'b1;
                  fail_q  <= mis;
                  if (mis && !(&fail_cnt_q)) fail_cnt_q <= fail_cnt_q + 1'b1;
                  state_q <= DONE_ST;
               end
            end
            DONE_ST: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

   assign bus.ready    = ready_q;
   assign bus.se       = se_q;
   assign bus.si       = pat_q[CHAIN_LEN-1];
   assign bus.done     = done_q;
   assign bus.rsp      = rsp_q;
   assign bus.fail     = fail_q;
   assign bus.fail_cnt = fail_cnt_q;

endmodule
